// File: rtl/motor_ramp_sequencer_pkg.sv
// Shared register map, field positions and scheduler states
// for the motor ramp sequencer.
package motor_ramp_sequencer_pkg;

  localparam logic [3:0] TGT_IDX  = 4'h0;
  localparam logic [3:0] STS_IDX  = 4'h4;
  localparam logic [3:0] RAMP_IDX = 4'h8;
  localparam int         MAX_CH   = 4;

  localparam int EN_BIT  = 31;
  localparam int DIR_BIT = 30;
  localparam int FLT_BIT = 29;
  localparam int RMP_BIT = 28;

  localparam logic [7:0] STEP_RST = 8'd1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } sched_t;

endpackage

// File: rtl/motor_ramp_sequencer_channel.sv
// One motor channel: duty ramp, direction reversal through zero,
// stall detection and latched fault.
module motor_ramp_channel
  import motor_ramp_sequencer_pkg::*;
#(
  parameter logic [7:0] STALL_DUTY  = 8'h40,
  parameter int         STALL_TICKS = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        upd,
  input  logic        tgt_en,
  input  logic        tgt_dir,
  input  logic [7:0]  tgt_duty,
  input  logic [7:0]  step,
  input  logic [31:0] pos,
  input  logic        fault_clr,
  output logic [7:0]  duty,
  output logic        en,
  output logic        dir,
  output logic        fault,
  output logic        ramping
);

  localparam int SW = $clog2(STALL_TICKS + 1);

  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] cnt_nxt;
  logic [31:0]   pos_q;
  logic [7:0]    eff;
  logic [7:0]    goal;
  logic [7:0]    diff;
  logic [7:0]    nxt;
  logic          flip;
  logic          stall_hit;
  logic          trip;

  always_comb begin
    eff  = (tgt_en && !fault) ? tgt_duty : 8'd0;
    flip = tgt_dir != dir;
    // a pending reversal must pass through zero duty first
    goal = (flip && duty != 8'd0) ? 8'd0 : eff;
    nxt  = goal;
    diff = 8'd0;
    if (duty < goal) begin
      diff = goal - duty;
      if (step != 8'd0 && step < diff) nxt = duty + step;
    end else begin
      diff = duty - goal;
      if (step != 8'd0 && step < diff) nxt = duty - step;
    end
    stall_hit = (duty >= STALL_DUTY) && (pos == pos_q);
    cnt_nxt   = stall_hit ? stall_cnt + SW'(1) : '0;
    trip      = stall_hit && (cnt_nxt == SW'(STALL_TICKS));
  end

  assign ramping = duty != eff;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      duty      <= '0;
      en        <= 1'b0;
      dir       <= 1'b0;
      fault     <= 1'b0;
      stall_cnt <= '0;
      pos_q     <= '0;
    end else begin
      if (upd) begin
        pos_q <= pos;
        if (trip) begin
          fault     <= 1'b1;
          duty      <= '0;
          en        <= 1'b0;
          stall_cnt <= '0;
        end else begin
          duty      <= nxt;
          en        <= nxt != 8'd0;
          stall_cnt <= cnt_nxt;
          if (duty == 8'd0) dir <= tgt_dir;
        end
      end
      if (fault_clr && !(upd && trip)) fault <= 1'b0;
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Wishbone-controlled ramp sequencer for COUNT motor channels,
// updated round-robin once per ramp tick.
module motor_ramp_sequencer
  import motor_ramp_sequencer_pkg::*;
#(
  parameter int         COUNT       = 4,
  parameter int         TICK_DIV    = 50000,
  parameter logic [7:0] STALL_DUTY  = 8'h40,
  parameter int         STALL_TICKS = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [31:0]          wb_adr,
  input  logic [3:0]           wb_sel,
  input  logic [31:0]          wb_mosi,
  output logic [31:0]          wb_miso,
  output logic                 wb_ack,
  output logic                 wb_err,
  input  logic [32*COUNT-1:0]  positions,
  output logic [COUNT-1:0]     motor_en,
  output logic [COUNT-1:0]     motor_dir,
  output logic [8*COUNT-1:0]   pwm_cmp,
  output logic [COUNT-1:0]     fault
);

  if (TICK_DIV < COUNT + 1) begin : g_bad_div
    $error("TICK_DIV must be at least COUNT+1");
  end
  if (COUNT > MAX_CH) begin : g_bad_count
    $error("COUNT exceeds the register map");
  end

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [COUNT-1:0]      tgt_en;
  logic [COUNT-1:0]      tgt_dir;
  logic [COUNT-1:0][7:0] tgt_duty;
  logic [7:0]            step;

  logic [COUNT-1:0] tgt_sel;
  logic [COUNT-1:0] sts_sel;
  logic [COUNT-1:0] fault_clr;
  logic [COUNT-1:0] ramping;
  logic [COUNT-1:0] upd_vec;
  logic             ramp_sel;
  logic             hit;
  logic [31:0]      rdata;
  logic [3:0]       reg_idx;
  logic             req;
  logic             new_req;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  sched_t        state;
  logic [CW-1:0] chan;

  logic unused;
  assign unused = ^{wb_adr[31:6], wb_adr[1:0], wb_sel[2:1], wb_mosi[28:8]};

  assign reg_idx = wb_adr[5:2];
  assign req     = wb_cyc & wb_stb;
  assign new_req = req & ~wb_ack & ~wb_err;

  always_comb begin
    tgt_sel   = '0;
    sts_sel   = '0;
    fault_clr = '0;
    rdata     = '0;
    ramp_sel  = reg_idx == RAMP_IDX;
    for (int i = 0; i < COUNT; i++) begin
      if (reg_idx == TGT_IDX + 4'(i)) begin
        tgt_sel[i]     = 1'b1;
        rdata[EN_BIT]  = tgt_en[i];
        rdata[DIR_BIT] = tgt_dir[i];
        rdata[7:0]     = tgt_duty[i];
      end
      if (reg_idx == STS_IDX + 4'(i)) begin
        sts_sel[i]     = 1'b1;
        rdata[EN_BIT]  = motor_en[i];
        rdata[DIR_BIT] = motor_dir[i];
        rdata[FLT_BIT] = fault[i];
        rdata[RMP_BIT] = ramping[i];
        rdata[7:0]     = pwm_cmp[8*i+:8];
      end
    end
    if (ramp_sel) rdata[7:0] = step;
    hit = (|tgt_sel) | (|sts_sel) | ramp_sel;
    fault_clr = sts_sel & {COUNT{new_req & wb_we & wb_sel[3]
                                 & wb_mosi[FLT_BIT]}};
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      wb_miso  <= '0;
      step     <= STEP_RST;
      tgt_en   <= '0;
      tgt_dir  <= '0;
      tgt_duty <= '0;
    end else if (!req) begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
    end else if (new_req) begin
      wb_ack  <= hit;
      wb_err  <= ~hit;
      wb_miso <= hit ? rdata : '0;
      if (wb_we) begin
        for (int i = 0; i < COUNT; i++) begin
          if (tgt_sel[i] && wb_sel[3]) begin
            tgt_en[i]  <= wb_mosi[EN_BIT];
            tgt_dir[i] <= wb_mosi[DIR_BIT];
          end
          if (tgt_sel[i] && wb_sel[0]) tgt_duty[i] <= wb_mosi[7:0];
        end
        if (ramp_sel && wb_sel[0]) step <= wb_mosi[7:0];
      end
    end
  end

  assign tick = tick_cnt == TW'(TICK_DIV - 1);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) tick_cnt <= '0;
    else          tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= ST_IDLE;
      chan  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          chan <= '0;
          if (tick) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (chan == CW'(COUNT - 1)) begin
            state <= ST_IDLE;
            chan  <= '0;
          end else begin
            chan <= chan + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    upd_vec = '0;
    for (int i = 0; i < COUNT; i++)
      upd_vec[i] = (state == ST_UPDATE) && (chan == CW'(i));
  end

  for (genvar i = 0; i < COUNT; i++) begin : g_ch
    motor_ramp_channel #(
      .STALL_DUTY (STALL_DUTY),
      .STALL_TICKS(STALL_TICKS)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .upd      (upd_vec[i]),
      .tgt_en   (tgt_en[i]),
      .tgt_dir  (tgt_dir[i]),
      .tgt_duty (tgt_duty[i]),
      .step     (step),
      .pos      (positions[32*i+:32]),
      .fault_clr(fault_clr[i]),
      .duty     (pwm_cmp[8*i+:8]),
      .en       (motor_en[i]),
      .dir      (motor_dir[i]),
      .fault    (fault[i]),
      .ramping  (ramping[i])
    );
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: ramp, reversal, stall,
// register map and asynchronous reset.
module tb_motor_ramp_sequencer;

  localparam int COUNT = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b0;
  logic         wb_cyc = 1'b0;
  logic         wb_stb = 1'b0;
  logic         wb_we = 1'b0;
  logic [31:0]  wb_adr = '0;
  logic [3:0]   wb_sel = '0;
  logic [31:0]  wb_mosi = '0;
  logic [31:0]  wb_miso;
  logic         wb_ack;
  logic         wb_err;
  logic [127:0] positions = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
  logic [3:0]   motor_en;
  logic [3:0]   motor_dir;
  logic [31:0]  pwm_cmp;
  logic [3:0]   fault;

  logic moving = 1'b1;
  int   ecnt = 0;
  int   total = 0;
  int   bad = 0;

  motor_ramp_sequencer #(
    .COUNT(COUNT), .TICK_DIV(10), .STALL_DUTY(8'h40), .STALL_TICKS(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_mosi(wb_mosi),
    .wb_miso(wb_miso), .wb_ack(wb_ack), .wb_err(wb_err),
    .positions(positions), .motor_en(motor_en),
    .motor_dir(motor_dir), .pwm_cmp(pwm_cmp), .fault(fault)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk)
    if (moving)
      for (int i = 0; i < COUNT; i++)
        positions[32*i+:32] <= positions[32*i+:32] + 32'(i + 1);

  always @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) ecnt = 0;
    else          ecnt = ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // returns once all channels have had one more update
  task automatic wait_upd();
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (ecnt % 10 != 4 && n < 25);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         output logic [31:0] rd, output logic a,
                         output logic e);
    int n = 0;
    @(negedge sys_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_sel = sel; wb_mosi = dat;
    do begin
      @(posedge sys_clk);
      #1;
      n++;
    end while (!(wb_ack || wb_err) && n < 8);
    a = wb_ack; e = wb_err; rd = wb_miso;
    chk("wb_latency", 32'(n), 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge sys_clk);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [3:0] sel,
                    input logic [31:0] dat);
    logic [31:0] rd;
    logic a, e;
    wb_xfer(1'b1, adr, sel, dat, rd, a, e);
    chk("wr_ack", {30'd0, a, e}, 32'd2);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic a, e;
    wb_xfer(1'b0, adr, 4'hF, 32'd0, rd, a, e);
    chk({tag, "_ack"}, {30'd0, a, e}, 32'd2);
    chk(tag, rd, exp);
  endtask

  logic [31:0] rdat;
  logic        ra;
  logic        re;

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_pwm", pwm_cmp, 32'd0);
    chk("rst_en", {28'd0, motor_en}, 32'd0);
    chk("rst_fault", {28'd0, fault}, 32'd0);
    chk("rst_wb", {wb_miso[30:0], wb_ack, wb_err}, 32'd0);
    sys_rst = 1'b1;

    rd_chk("ramp_rst", 32'h20, 32'd1);
    wr(32'h00, 4'hF, 32'h8000_0010);
    wr(32'h20, 4'hF, 32'd4);

    wait_upd();
    chk("ramp_4", {24'd0, pwm_cmp[7:0]}, 32'h04);
    chk("ramp_en", {31'd0, motor_en[0]}, 32'd1);
    rd_chk("sts_ramping", 32'h10, 32'h9000_0004);
    wait_upd();
    chk("ramp_8", {24'd0, pwm_cmp[7:0]}, 32'h08);
    wait_upd();
    chk("ramp_12", {24'd0, pwm_cmp[7:0]}, 32'h0C);
    wait_upd();
    chk("ramp_16", {24'd0, pwm_cmp[7:0]}, 32'h10);
    wait_upd();
    chk("ramp_hold", {24'd0, pwm_cmp[7:0]}, 32'h10);
    rd_chk("sts_settled", 32'h10, 32'h8000_0010);

    wr(32'h00, 4'hF, 32'hC000_0010);
    wait_upd();
    chk("rev_12", {23'd0, motor_dir[0], pwm_cmp[7:0]}, 32'h00C);
    wait_upd();
    chk("rev_8", {23'd0, motor_dir[0], pwm_cmp[7:0]}, 32'h008);
    wait_upd();
    chk("rev_4", {23'd0, motor_dir[0], pwm_cmp[7:0]}, 32'h004);
    wait_upd();
    chk("rev_0", {23'd0, motor_dir[0], pwm_cmp[7:0]}, 32'h000);
    chk("rev_0_en", {31'd0, motor_en[0]}, 32'd0);
    wait_upd();
    chk("rev_up4", {23'd0, motor_dir[0], pwm_cmp[7:0]}, 32'h104);
    wait_upd();
    wait_upd();
    wait_upd();
    chk("rev_up16", {23'd0, motor_dir[0], pwm_cmp[7:0]}, 32'h110);
    rd_chk("sts_rev", 32'h10, 32'hC000_0010);

    wr(32'h00, 4'b0001, 32'h0000_0020);
    rd_chk("tgt_lane", 32'h00, 32'hC000_0020);
    wait_upd();
    chk("lane_ramp", {24'd0, pwm_cmp[7:0]}, 32'h14);

    moving = 1'b0;
    wr(32'h20, 4'hF, 32'd0);
    wr(32'h04, 4'hF, 32'h8000_0080);
    wait_upd();
    chk("stall_duty", {16'd0, pwm_cmp[15:0]}, 32'h8020);
    wait_upd();
    wait_upd();
    wait_upd();
    chk("stall_3", {28'd0, fault}, 32'd0);
    wait_upd();
    chk("stall_trip", {28'd0, fault}, 32'b0010);
    chk("stall_off", {23'd0, motor_en[1], pwm_cmp[15:8]}, 32'd0);
    rd_chk("sts_fault", 32'h14, 32'h2000_0000);
    wr(32'h14, 4'hF, 32'hDFFF_FFFF);
    wait_upd();
    chk("flt_kept", {28'd0, fault}, 32'b0010);
    rd_chk("tgt1_kept", 32'h04, 32'h8000_0080);
    wr(32'h14, 4'b1000, 32'h2000_0000);
    chk("flt_clr", {28'd0, fault}, 32'd0);
    moving = 1'b1;
    rd_chk("sts_clr", 32'h14, 32'h1000_0000);
    wait_upd();
    chk("restart", {23'd0, motor_en[1], pwm_cmp[15:8]}, 32'h180);

    wr(32'h08, 4'hF, 32'h8000_00FF);
    wb_xfer(1'b0, 32'h30, 4'hF, 32'd0, rdat, ra, re);
    chk("err_rd", {30'd0, ra, re}, 32'd1);
    wb_xfer(1'b1, 32'h24, 4'hF, 32'd0, rdat, ra, re);
    chk("err_wr", {30'd0, ra, re}, 32'd1);
    wait_upd();
    chk("jump_ff", {24'd0, pwm_cmp[23:16]}, 32'hFF);

    wr(32'h20, 4'hF, 32'd1);
    wr(32'h0C, 4'hF, 32'h8000_0040);
    wait_upd();
    wait_upd();
    chk("pre_rst_pwm", pwm_cmp, 32'h02FF_8020);
    chk("pre_rst_io", {24'd0, motor_en, motor_dir}, 32'hF1);
    #2;
    sys_rst = 1'b0;
    #1;
    chk("async_pwm", pwm_cmp, 32'd0);
    chk("async_io", {20'd0, motor_en, motor_dir, fault}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    rd_chk("ramp_after", 32'h20, 32'd1);
    rd_chk("tgt2_after", 32'h08, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
